// File: rtl/icache.sv
// Direct-mapped instruction cache between the instruction-fetch unit and the
// memory controller's line-fetch port. A hit answers one cycle after the
// request. A miss fetches the whole line, writes it, and then replays the
// held request.
// Optional build macro: ICACHE_STAT_EN adds saturating hit/miss counters and
// their hit_cnt/miss_cnt output ports.
module icache #(
  parameter int LINE_BYTES = 16,
  parameter int NUM_LINES  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    rollback,
  input  logic                    ifu_req,
  input  logic [31:0]             ifu_pc,
  output logic                    ifu_valid,
  output logic [31:0]             ifu_inst,
  output logic                    mem_en,
  output logic [31:0]             mem_pc,
  input  logic                    mem_done,
  input  logic [LINE_BYTES*8-1:0] mem_data
`ifdef ICACHE_STAT_EN
  ,
  output logic [31:0]             hit_cnt,
  output logic [31:0]             miss_cnt
`endif
);

  localparam int OFF_W  = $clog2(LINE_BYTES);
  localparam int IDX_W  = $clog2(NUM_LINES);
  localparam int TAG_W  = 32 - OFF_W - IDX_W;
  localparam int WORDS  = LINE_BYTES / 4;
  localparam int WSEL_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {IDLE, MISS, RETURN} state_e;

  state_e                 state_q, state_d;
  logic                   ifuValid_q, ifuValid_d;
  logic [31:0]            ifuInst_q, ifuInst_d;
  logic                   memEn_q, memEn_d;
  logic [31:0]            memPc_q, memPc_d;

  logic [NUM_LINES-1:0]   valid_q;
  logic [TAG_W-1:0]       tag_q  [NUM_LINES];
  logic [WORDS-1:0][31:0] data_q [NUM_LINES];

  logic [IDX_W-1:0]       reqIdx;
  logic [TAG_W-1:0]       reqTag;
  logic [OFF_W-1:0]       reqOff;
  logic [WSEL_W-1:0]      reqWord;
  logic [IDX_W-1:0]       fillIdx;
  logic [TAG_W-1:0]       fillTag;
  logic                   isHit;
  logic                   doLookup;
  logic                   fillEn;

  assign reqIdx  = ifu_pc[OFF_W +: IDX_W];
  assign reqTag  = ifu_pc[31 -: TAG_W];
  assign reqOff  = ifu_pc[OFF_W-1:0];
  assign reqWord = WSEL_W'(reqOff >> 2);
  // The fill target comes from the latched miss address, so it does not
  // depend on whatever the IFU presents after a rollback.
  assign fillIdx = memPc_q[OFF_W +: IDX_W];
  assign fillTag = memPc_q[31 -: TAG_W];

  assign isHit    = valid_q[reqIdx] && (tag_q[reqIdx] == reqTag);
  // A response cycle blocks the lookup because the IFU still shows the old pc.
  assign doLookup = rdy && (state_q == IDLE) && ifu_req && !ifuValid_q && !rollback;
  assign fillEn   = rdy && (state_q == MISS) && mem_done;

  assign ifu_valid = ifuValid_q && rdy;
  assign ifu_inst  = ifuInst_q;
  assign mem_en    = memEn_q;
  assign mem_pc    = memPc_q;

  // Next-state and output decode. A low rdy keeps every register at its value.
  // Otherwise the response pulse clears by default, which also covers rollback.
  always_comb begin
    state_d    = state_q;
    ifuValid_d = ifuValid_q;
    ifuInst_d  = ifuInst_q;
    memEn_d    = memEn_q;
    memPc_d    = memPc_q;
    if (rdy) begin
      ifuValid_d = 1'b0;
      unique case (state_q)
        IDLE: begin
          if (doLookup) begin
            if (isHit) begin
              ifuValid_d = 1'b1;
              ifuInst_d  = data_q[reqIdx][reqWord];
            end else begin
              memEn_d = 1'b1;
              memPc_d = {ifu_pc[31:OFF_W], {OFF_W{1'b0}}};
              state_d = MISS;
            end
          end
        end
        MISS: begin
          if (mem_done) begin
            memEn_d = 1'b0;
            state_d = RETURN;
          end
        end
        RETURN:  state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // State, response and fetch-request registers. Reset wins over rdy and rollback.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ifuValid_q <= 1'b0;
      ifuInst_q  <= '0;
      memEn_q    <= 1'b0;
      memPc_q    <= '0;
    end else begin
      state_q    <= state_d;
      ifuValid_q <= ifuValid_d;
      ifuInst_q  <= ifuInst_d;
      memEn_q    <= memEn_d;
      memPc_q    <= memPc_d;
    end
  end

  // Valid bits are cleared by reset and set when a line fill lands.
  // A fill completes even during a rollback, and the line is kept.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (fillEn) begin
      valid_q[fillIdx] <= 1'b1;
    end
  end

  // Tag and data arrays need no reset. The valid bit guards them.
  always_ff @(posedge clk) begin
    if (fillEn && !rst) begin
      tag_q[fillIdx]  <= fillTag;
      data_q[fillIdx] <= mem_data;
    end
  end

`ifdef ICACHE_STAT_EN
  logic        replay_q;
  logic [31:0] hitCnt_q;
  logic [31:0] missCnt_q;
  logic        countHit;
  logic        countMiss;

  // The first lookup after a fill replays an access already counted as a miss.
  // It is therefore not counted again as a hit.
  assign countHit  = doLookup && isHit && !replay_q;
  assign countMiss = doLookup && !isHit;

  assign hit_cnt  = hitCnt_q;
  assign miss_cnt = missCnt_q;

  // Track the replay cycle and bump the saturating counters. doLookup already
  // excludes rdy-low and rollback cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      replay_q  <= 1'b0;
      hitCnt_q  <= '0;
      missCnt_q <= '0;
    end else begin
      if (rdy) begin
        replay_q <= (state_q == RETURN);
      end
      if (countHit && (hitCnt_q != 32'hFFFF_FFFF)) begin
        hitCnt_q <= hitCnt_q + 32'd1;
      end
      if (countMiss && (missCnt_q != 32'hFFFF_FFFF)) begin
        missCnt_q <= missCnt_q + 32'd1;
      end
    end
  end
`endif

endmodule
